// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - PS/2 keyboard device model: ASCII in, set-2 make/break frames out on ps2_clk/ps2_data.
// Optional PS2_TX_SHIFT_EN: uppercase letters are typed wrapped in Left-Shift make/break.
module ps2_kbd_tx #(
  parameter int CLK_DIV = 8,
  parameter int GAP     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] ascii,
  output logic       ready,
  output logic       busy,
  output logic       err,
  output logic       ps2_clk,
  output logic       ps2_data
);

`ifdef PS2_TX_SHIFT_EN
  localparam int QDEPTH = 6;
`else
  localparam int QDEPTH = 3;
`endif

  localparam int CMAX = (2 * CLK_DIV > GAP) ? 2 * CLK_DIV : GAP;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] FALL_AT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP - 1);
  localparam logic [7:0] BREAK  = 8'hF0;
  localparam logic [7:0] LSHIFT = 8'h12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [2:0]    qlen;
  logic [7:0]    queue [QDEPTH];

  logic       hit;
  logic [7:0] code;
`ifdef PS2_TX_SHIFT_EN
  logic       shifted;
`endif

  // {hit, code}: set-2 make code for the characters the keyboard can type
  function automatic logic [8:0] set2_code(input logic [7:0] ch);
    logic [8:0] r;
    r = 9'h000;
    case (ch)
      8'h61: r = 9'h11C;  8'h62: r = 9'h132;  8'h63: r = 9'h121;  8'h64: r = 9'h123;
      8'h65: r = 9'h124;  8'h66: r = 9'h12B;  8'h67: r = 9'h134;  8'h68: r = 9'h133;
      8'h69: r = 9'h143;  8'h6A: r = 9'h13B;  8'h6B: r = 9'h142;  8'h6C: r = 9'h14B;
      8'h6D: r = 9'h13A;  8'h6E: r = 9'h131;  8'h6F: r = 9'h144;  8'h70: r = 9'h14D;
      8'h71: r = 9'h115;  8'h72: r = 9'h12D;  8'h73: r = 9'h11B;  8'h74: r = 9'h12C;
      8'h75: r = 9'h13C;  8'h76: r = 9'h12A;  8'h77: r = 9'h11D;  8'h78: r = 9'h122;
      8'h79: r = 9'h135;  8'h7A: r = 9'h11A;
      8'h30: r = 9'h145;  8'h31: r = 9'h116;  8'h32: r = 9'h11E;  8'h33: r = 9'h126;
      8'h34: r = 9'h125;  8'h35: r = 9'h12E;  8'h36: r = 9'h136;  8'h37: r = 9'h13D;
      8'h38: r = 9'h13E;  8'h39: r = 9'h146;
      8'h20: r = 9'h129;
      8'h0A: r = 9'h15A;
      8'h08: r = 9'h166;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  always_comb begin
    {hit, code} = set2_code(ascii);
`ifdef PS2_TX_SHIFT_EN
    shifted = 1'b0;
    if (ascii >= 8'h41 && ascii <= 8'h5A) begin
      {hit, code} = set2_code(ascii | 8'h20);
      shifted = 1'b1;
    end
`endif
  end

  assign ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      qlen     <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      for (int i = 0; i < QDEPTH; i++) queue[i] <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid) begin
            if (hit) begin
              for (int i = 0; i < QDEPTH; i++) queue[i] <= '0;
`ifdef PS2_TX_SHIFT_EN
              if (shifted) begin
                queue[0] <= LSHIFT;
                queue[1] <= code;
                queue[2] <= BREAK;
                queue[3] <= code;
                queue[4] <= BREAK;
                queue[5] <= LSHIFT;
                qlen     <= 3'd6;
              end else begin
                queue[0] <= code;
                queue[1] <= BREAK;
                queue[2] <= code;
                qlen     <= 3'd3;
              end
`else
              queue[0] <= code;
              queue[1] <= BREAK;
              queue[2] <= code;
              qlen     <= 3'd3;
`endif
              byte_idx <= '0;
              cnt      <= '0;
              busy     <= 1'b1;
              ps2_clk  <= 1'b1;
              ps2_data <= 1'b0;
              state    <= S_START;
            end else begin
              err <= 1'b1;
            end
          end
        end

        // every bit: CLK_DIV cycles high (data changes here), CLK_DIV low
        S_START, S_BIT, S_PARITY, S_STOP: begin
          if (cnt == FALL_AT) ps2_clk <= 1'b0;
          if (cnt == BIT_END) begin
            cnt     <= '0;
            ps2_clk <= 1'b1;
            case (state)
              S_START: begin
                bit_idx  <= '0;
                ps2_data <= queue[0][0];
                state    <= S_BIT;
              end
              S_BIT: begin
                if (bit_idx == 3'd7) begin
                  ps2_data <= ~^queue[0];
                  state    <= S_PARITY;
                end else begin
                  bit_idx  <= bit_idx + 3'd1;
                  ps2_data <= queue[0][bit_idx + 3'd1];
                end
              end
              S_PARITY: begin
                ps2_data <= 1'b1;
                state    <= S_STOP;
              end
              default: begin
                ps2_data <= 1'b1;
                state    <= S_GAP;
              end
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_END) begin
            cnt <= '0;
            if (byte_idx + 3'd1 < qlen) begin
              byte_idx <= byte_idx + 3'd1;
              for (int i = 0; i < QDEPTH - 1; i++) queue[i] <= queue[i+1];
              queue[QDEPTH-1] <= '0;
              ps2_data <= 1'b0;
              state    <= S_START;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb/tb_ps2_kbd_tx.sv - scoreboard bench: reference keymap model, frame-decoding monitor, timing checks.
module tb_ps2_kbd_tx;
  localparam int CD  = 4;
  localparam int GP  = 8;
  localparam int FRM = 22 * CD + GP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       ready, busy, err, ps2_clk, ps2_data;

  ps2_kbd_tx #(.CLK_DIV(CD), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ascii(ascii),
    .ready(ready), .busy(busy), .err(err),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // reference keymap: table lookup by character class
  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic int model_push(input logic [7:0] c);
    int code;
    bit sh;
    logic [7:0] lc;
    code = -1;
    sh = 1'b0;
    lc = c;
`ifdef PS2_TX_SHIFT_EN
    if (c >= 8'h41 && c <= 8'h5A) begin
      lc = c + 8'd32;
      sh = 1'b1;
    end
`endif
    if (lc >= 8'h61 && lc <= 8'h7A) code = int'(LETTERS[lc - 8'h61]);
    else if (lc >= 8'h30 && lc <= 8'h39) code = int'(DIGITS[lc - 8'h30]);
    else if (lc == 8'h20) code = 'h29;
    else if (lc == 8'h0A) code = 'h5A;
    else if (lc == 8'h08) code = 'h66;
    if (code < 0) return 0;
    if (sh) begin
      exp_q.push_back(8'h12);
      exp_q.push_back(8'(code));
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'(code));
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h12);
      return 6;
    end
    exp_q.push_back(8'(code));
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'(code));
    return 3;
  endfunction

  // monitor: host-side receiver sampling data on each ps2_clk falling edge
  logic bits [11];
  int   nbits = 0;
  int   first_fall = 0;
  int   last_end = 0;
  int   frames = 0;
  bit   have_last = 1'b0;
  bit   cont = 1'b0;
  bit   idle_bad = 1'b0;
  logic prev_clk = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      have_last = 1'b0;
      prev_clk = 1'b1;
      exp_q.delete();
    end else begin
      if (!busy) begin
        cont = 1'b0;
        if (ps2_clk === 1'b0 || ps2_data === 1'b0) idle_bad = 1'b1;
      end
      if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
        if (nbits == 0) begin
          first_fall = cyc;
          if (have_last && cont) chk("inter_frame_gap", first_fall - last_end, 2 * CD + GP);
        end
        bits[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          logic [7:0] b;
          for (int i = 0; i < 8; i++) b[i] = bits[i+1];
          chk("start_bit", bits[0], 0);
          chk("stop_bit", bits[10], 1);
          chk("odd_parity", ^{b, bits[9]}, 1);
          chk("frame_span", cyc - first_fall, 20 * CD);
          if (exp_q.size() == 0) chk("unexpected_frame", b, 32'h100);
          else chk("frame_byte", b, exp_q.pop_front());
          frames++;
          last_end = cyc;
          have_last = 1'b1;
          cont = 1'b1;
          nbits = 0;
        end
      end
      prev_clk = ps2_clk;
    end
  end

  task automatic send(input logic [7:0] c, input bit keep_valid, input bit measure);
    int n;
    int nb;
    bit bad;
    ascii = c;
    valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", ready, 1);
      valid = 1'b0;
      return;
    end
    nb = model_push(c);
    @(posedge clk);
    #1;
    if (!keep_valid) valid = 1'b0;
    if (nb == 0) begin
      chk("err_pulse", err, 1);
      bad = 1'b0;
      repeat (6) begin
        if (!(ps2_clk && ps2_data && ready && !busy)) bad = 1'b1;
        @(posedge clk);
        #1;
        if (err) bad = 1'b1;
      end
      chk("unmapped_quiet", bad, 0);
    end else begin
      chk("accept_plus1", {busy, ps2_clk, ps2_data, err}, 4'b1100);
      if (measure) begin
        n = 1;
        repeat (CD - 1) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("clk_high_before_fall", ps2_clk, 1);
        @(posedge clk);
        #1;
        n++;
        chk("first_fall", ps2_clk, 0);
        while (busy && n < 30000) begin
          @(posedge clk);
          #1;
          if (busy) n++;
        end
        chk("busy_len", n, nb * FRM);
        chk("ready_on_busy_fall", ready, 1);
      end
    end
  endtask

  string mapped_chars = "abcdefghijklmnopqrstuvwxyz0123456789 ";

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] c;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ps2_clk, ps2_data, busy, err, ready}, 5'b11000);
    rst = 1'b0;
    #1;
    chk("reset_ready", ready, 1);

    send(8'h61, 1'b0, 1'b1);
    send(8'h80, 1'b0, 1'b0);

    send(8'h20, 1'b1, 1'b0);
    send(8'h0A, 1'b0, 1'b0);

    send(8'h31, 1'b0, 1'b0);
    repeat (10 * CD + 2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_frame_reset", {ps2_clk, ps2_data, busy, ready, err}, 5'b11010);
    send(8'h30, 1'b0, 1'b1);

    send(8'h41, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) c = mapped_chars[$urandom_range(0, mapped_chars.len() - 1)];
      else c = 8'($urandom_range(0, 255));
      send(c, 1'b0, 1'b1);
    end

    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("idle_lines_high", idle_bad, 0);
    chk("min_frame_count", frames >= 15, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
